// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request port, WAIT_CYCLES wait states, one response pulse per request.
// Optional feature: define DMEM_BOUNDS_EN to flag and suppress accesses at or above DEPTH_WORDS*4.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    logic [1:0]    state;
    logic [3:0]    cnt;
    req_t          lat;
    req_t          cur;
    logic [31:0]   mem [DEPTH_WORDS];
    logic          accept;
    logic          enter_resp;
    logic [AW-1:0] idx;
    logic          addr_err;
    logic [31:0]   bmask;
    logic          unused_addr;

    assign req_ready  = reset && (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign busy       = (state != S_IDLE);
    assign accept     = req_valid && req_ready;

    // With zero wait states the commit happens on the accept edge, so it must see the live request.
    assign cur        = (state == S_IDLE) ? '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be} : lat;
    assign enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == S_WAIT) && (cnt == 4'd1));
    assign idx        = cur.addr[AW+1:2];

`ifdef DMEM_BOUNDS_EN
    assign addr_err = (cur.addr >= 32'(DEPTH_WORDS * 4));
`else
    assign addr_err = 1'b0;
`endif
    assign unused_addr = ^{cur.addr[31:AW+2], cur.addr[1:0]};

    always_comb begin
        bmask = '0;
        for (int i = 0; i < 4; i++) bmask[8*i +: 8] = {8{cur.be[i]}};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            lat        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    lat   <= cur;
                    cnt   <= 4'(WAIT_CYCLES);
                    state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= S_RESP;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (enter_resp) begin
                resp_rdata <= (cur.we || addr_err) ? 32'h0 : mem[idx];
                resp_err   <= addr_err;
            end
        end
    end

    // Storage is deliberately not reset; gating on reset drops a store still in flight.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && cur.we && !addr_err)
            mem[idx] <= (mem[idx] & ~bmask) | (cur.wdata & bmask);
    end
endmodule
